sonar_uc: RTL and testbench

- Control unit for the sonar datapath: sequences the ultrasonic measurement, the 8-character serial frame and the servo step.
- Sits beside the sonar datapath. Drives its measure, transmit, serial-mux select and position-advance controls. Consumes its end-of-measurement and end-of-transmission flags.
- Owns the inter-position dwell timer, so the datapath no longer needs a free-running 2 s counter.

---
 rtl/sonar_uc_pkg.sv | 25 ++
 rtl/sonar_uc_if.sv | 29 ++
 rtl/sonar_uc_contador_espera.sv | 30 +++
 rtl/sonar_uc.sv | 143 ++++++++++++++
 tb/tb_sonar_uc.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/sonar_uc_pkg.sv
// sonar_pkg: shared definitions for the sonar control unit.
//   estado_t     - FSM state codes, also exported on db_estado
//   N_CHARS_DEF  - default characters per serial frame
//   IDX_*        - fixed character positions inside the frame
package sonar_pkg;

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARA        = 4'h1,
        MEDE           = 4'h2,
        AGUARDA_MEDIDA = 4'h3,
        TRANSMITE      = 4'h4,
        AGUARDA_TX     = 4'h5,
        PROXIMO        = 4'h6,
        ESPERA         = 4'h7,
        MOVE           = 4'h8,
        ERRO           = 4'hF
    } estado_t;

    localparam int         N_CHARS_DEF = 8;
    // Frame: ang_c ang_d ang_u ',' dist_c dist_d dist_u '#'
    localparam logic [2:0] IDX_VIRGULA = 3'd3;
    localparam logic [2:0] IDX_FIM     = 3'd7;

endpackage

// File: rtl/sonar_uc_if.sv
// sonar_uc_if: control/status bundle between the sonar control unit and
// its datapath.
//   master - control unit side (consumes flags, drives controls)
//   slave  - datapath side
interface sonar_uc_if;
    logic       ligar;
    logic       fim_medicao;
    logic       fim_transmissao;
    logic       zera;
    logic       medir;
    logic       transmitir;
    logic [2:0] sel_char;
    logic       avanca_posicao;
    logic       pronto;
    logic       erro_medida;
    logic [3:0] db_estado;

    modport master (
        input  ligar, fim_medicao, fim_transmissao,
        output zera, medir, transmitir, sel_char, avanca_posicao,
               pronto, erro_medida, db_estado
    );

    modport slave (
        output ligar, fim_medicao, fim_transmissao,
        input  zera, medir, transmitir, sel_char, avanca_posicao,
               pronto, erro_medida, db_estado
    );
endinterface

// File: rtl/sonar_uc_contador_espera.sv
// contador_espera: terminal-count timer.
//   clock, reset - clock, async active-low reset
//   i_zera       - synchronous clear (priority over i_conta)
//   i_conta      - count enable; counter holds at N-1
//   o_fim        - high while the count equals N-1
module contador_espera #(
    parameter int N = 100_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic i_zera,
    input  logic i_conta,
    output logic o_fim
);
    localparam int         W   = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] ULT = W'(N - 1);

    logic [W-1:0] r_cont;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_cont <= '0;
        else if (i_zera)
            r_cont <= '0;
        else if (i_conta && !o_fim)
            r_cont <= r_cont + W'(1);
    end

    assign o_fim = (r_cont == ULT);
endmodule

// File: rtl/sonar_uc.sv
// sonar_uc: control unit of the sonar datapath. Sequences one ultrasonic
// measurement, the N_CHARS-character serial frame, the dwell time and the
// servo step.
//   clock, reset - clock, async active-low reset
//   bus          - sonar_uc_if.master: ligar/fim_* in, controls + db_estado out
// Optional build macro SONAR_UC_WATCHDOG_EN adds a measurement watchdog
// (state ERRO, sticky erro_medida).
module sonar_uc
    import sonar_pkg::*;
#(
    parameter int ESPERA_CICLOS  = 100_000_000,
    parameter int N_CHARS        = N_CHARS_DEF,
    parameter int TIMEOUT_CICLOS = 1_500_000
) (
    input  logic          clock,
    input  logic          reset,
    sonar_uc_if.master    bus
);
    localparam logic [2:0] IDX_ULT = 3'(N_CHARS - 1);

    estado_t    r_estado;
    logic [2:0] r_idx;
    logic       r_zera, r_medir, r_transmitir, r_avanca, r_pronto;
    logic       w_fim_espera;

    contador_espera #(.N(ESPERA_CICLOS)) u_espera (
        .clock   (clock),
        .reset   (reset),
        .i_zera  (r_estado == MOVE),
        .i_conta (r_estado == ESPERA),
        .o_fim   (w_fim_espera)
    );

`ifdef SONAR_UC_WATCHDOG_EN
    logic r_erro;
    logic w_fim_wdog;

    // Cleared everywhere else, so every wait starts from zero.
    contador_espera #(.N(TIMEOUT_CICLOS)) u_wdog (
        .clock   (clock),
        .reset   (reset),
        .i_zera  (r_estado != AGUARDA_MEDIDA),
        .i_conta (r_estado == AGUARDA_MEDIDA),
        .o_fim   (w_fim_wdog)
    );

    assign bus.erro_medida = r_erro;
`else
    // Always 0 in this build; the comparison only keeps the shared
    // parameter list referenced.
    assign bus.erro_medida = (TIMEOUT_CICLOS < 0);
`endif

    // Outputs are registered alongside the state, so each pulse lines up
    // with the state that owns it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado     <= INICIAL;
            r_idx        <= '0;
            r_zera       <= 1'b0;
            r_medir      <= 1'b0;
            r_transmitir <= 1'b0;
            r_avanca     <= 1'b0;
            r_pronto     <= 1'b0;
`ifdef SONAR_UC_WATCHDOG_EN
            r_erro       <= 1'b0;
`endif
        end else begin
            r_zera       <= 1'b0;
            r_medir      <= 1'b0;
            r_transmitir <= 1'b0;
            r_avanca     <= 1'b0;
            r_pronto     <= 1'b0;
            case (r_estado)
                INICIAL: if (bus.ligar) begin
                    r_estado <= PREPARA;
                    r_zera   <= 1'b1;
`ifdef SONAR_UC_WATCHDOG_EN
                    r_erro   <= 1'b0;
`endif
                end
                PREPARA: begin
                    r_idx    <= '0;
                    r_estado <= MEDE;
                    r_medir  <= 1'b1;
                end
                MEDE: r_estado <= AGUARDA_MEDIDA;
                AGUARDA_MEDIDA: begin
                    // A flag arriving with the timeout takes precedence.
                    if (bus.fim_medicao) begin
                        r_estado     <= TRANSMITE;
                        r_transmitir <= 1'b1;
                    end
`ifdef SONAR_UC_WATCHDOG_EN
                    else if (w_fim_wdog) begin
                        r_estado <= ERRO;
                        r_erro   <= 1'b1;
                    end
`endif
                end
                TRANSMITE: r_estado <= AGUARDA_TX;
                AGUARDA_TX: if (bus.fim_transmissao) r_estado <= PROXIMO;
                PROXIMO: begin
                    if (r_idx == IDX_ULT) begin
                        r_estado <= ESPERA;
                    end else begin
                        r_idx        <= r_idx + 3'd1;
                        r_estado     <= TRANSMITE;
                        r_transmitir <= 1'b1;
                    end
                end
                ESPERA: if (w_fim_espera) begin
                    r_estado <= MOVE;
                    r_avanca <= 1'b1;
                    r_pronto <= 1'b1;
                end
                MOVE: begin
                    // MOVE->MEDE bypasses PREPARA, so the next frame's
                    // index is rewound here.
                    r_idx <= '0;
                    if (bus.ligar) begin
                        r_estado <= MEDE;
                        r_medir  <= 1'b1;
                    end else begin
                        r_estado <= INICIAL;
                    end
                end
`ifdef SONAR_UC_WATCHDOG_EN
                ERRO: r_estado <= ESPERA;
`endif
                default: r_estado <= INICIAL;
            endcase
        end
    end

    assign bus.zera           = r_zera;
    assign bus.medir          = r_medir;
    assign bus.transmitir     = r_transmitir;
    assign bus.sel_char       = r_idx;
    assign bus.avanca_posicao = r_avanca;
    assign bus.pronto         = r_pronto;
    assign bus.db_estado      = r_estado;
endmodule

// File: tb/tb_sonar_uc.sv
module tb_sonar_uc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    sonar_uc_if bus ();

    sonar_uc #(.ESPERA_CICLOS(20), .N_CHARS(8), .TIMEOUT_CICLOS(50)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic       lig, fm, ft;
        logic [3:0] st;
        logic       z, m, t;
        logic [2:0] sel;
        logic       av, pr;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        bus.ligar = 1'b0;
        bus.fim_medicao = 1'b0;
        bus.fim_transmissao = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Entry: state MEDE just observed. Serves a frame: fim_medicao 5 cycles
    // into the wait, each fim_transmissao 3 cycles after its transmitir.
    // drop_at: char at which ligar falls; stop_at: return in AGUARDA_TX.
    task automatic serve_frame(input int drop_at, input int stop_at);
        int n;
        step();
        chk("aguarda_medida", {28'd0, bus.db_estado}, 32'h3);
        repeat (4) step();
        bus.fim_medicao = 1'b1;
        step();
        bus.fim_medicao = 1'b0;
        for (int c = 0; c < 8; c++) begin
            chk("tx_pulse", {bus.db_estado, bus.transmitir, bus.sel_char},
                {4'h4, 1'b1, 3'(c)});
            if (c == drop_at) bus.ligar = 1'b0;
            step();
            chk("aguarda_tx", {bus.db_estado, bus.transmitir, bus.sel_char},
                {4'h5, 1'b0, 3'(c)});
            if (c == stop_at) return;
            step();
            bus.fim_transmissao = 1'b1;
            step();
            bus.fim_transmissao = 1'b0;
            chk("proximo", {bus.db_estado, bus.sel_char}, {4'h6, 3'(c)});
            step();
        end
        chk("espera_ini", {28'd0, bus.db_estado}, 32'h7);
        n = 0;
        for (int i = 1; i < 20; i++) begin
            step();
            if (bus.db_estado == 4'h7 && !bus.avanca_posicao && !bus.pronto) n++;
        end
        chk("espera_len", n, 19);
        step();
        chk("move", {bus.db_estado, bus.avanca_posicao, bus.pronto}, {4'h8, 1'b1, 1'b1});
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        //            lig fm ft st    z  m  t  sel  av pr
        tbl[0]  = '{1, 0, 0, 4'h1, 1, 0, 0, 3'd0, 0, 0};
        tbl[1]  = '{1, 0, 0, 4'h2, 0, 1, 0, 3'd0, 0, 0};
        tbl[2]  = '{1, 0, 0, 4'h3, 0, 0, 0, 3'd0, 0, 0};
        tbl[3]  = '{1, 0, 1, 4'h3, 0, 0, 0, 3'd0, 0, 0};
        tbl[4]  = '{1, 0, 0, 4'h3, 0, 0, 0, 3'd0, 0, 0};
        tbl[5]  = '{1, 1, 0, 4'h4, 0, 0, 1, 3'd0, 0, 0};
        tbl[6]  = '{1, 1, 0, 4'h5, 0, 0, 0, 3'd0, 0, 0};
        tbl[7]  = '{1, 1, 0, 4'h5, 0, 0, 0, 3'd0, 0, 0};
        tbl[8]  = '{1, 0, 1, 4'h6, 0, 0, 0, 3'd0, 0, 0};
        tbl[9]  = '{1, 0, 0, 4'h4, 0, 0, 1, 3'd1, 0, 0};
        tbl[10] = '{1, 0, 0, 4'h5, 0, 0, 0, 3'd1, 0, 0};

        bus.ligar = 1'b0;
        bus.fim_medicao = 1'b0;
        bus.fim_transmissao = 1'b0;
        step();
        chk("reset_state", {bus.db_estado, bus.zera, bus.medir, bus.transmitir,
            bus.sel_char, bus.avanca_posicao, bus.pronto, bus.erro_medida}, 0);
        step();
        rst_n = 1'b1;

        // Startup, spurious flags and the first character, cycle by cycle.
        for (int i = 0; i < 11; i++) begin
            bus.ligar = tbl[i].lig;
            bus.fim_medicao = tbl[i].fm;
            bus.fim_transmissao = tbl[i].ft;
            step();
            chk($sformatf("vec%0d", i),
                {bus.db_estado, bus.zera, bus.medir, bus.transmitir, bus.sel_char,
                 bus.avanca_posicao, bus.pronto},
                {tbl[i].st, tbl[i].z, tbl[i].m, tbl[i].t, tbl[i].sel, tbl[i].av, tbl[i].pr});
        end
        bus.fim_medicao = 1'b0;
        bus.fim_transmissao = 1'b0;

        // Full frame with ligar held, then a second frame dropping ligar at char 4.
        reset_dut();
        bus.ligar = 1'b1;
        step();
        chk("start_zera", {bus.db_estado, bus.zera}, {4'h1, 1'b1});
        step();
        chk("start_medir", {bus.db_estado, bus.medir}, {4'h2, 1'b1});
        serve_frame(-1, -1);
        chk("rerun_medir", {bus.db_estado, bus.medir, bus.sel_char}, {4'h2, 1'b1, 3'd0});
        serve_frame(4, -1);
        chk("drop_inicial", {28'd0, bus.db_estado}, 32'h0);
        n = 0;
        repeat (10) begin
            step();
            if (bus.medir || bus.zera || bus.db_estado != 4'h0) n++;
        end
        chk("drop_idle", n, 0);

        // Async reset while waiting on character 5.
        bus.ligar = 1'b1;
        step();
        step();
        chk("restart_medir", {bus.db_estado, bus.medir}, {4'h2, 1'b1});
        serve_frame(-1, 5);
        rst_n = 1'b0;
        #1;
        chk("async_reset", {bus.db_estado, bus.zera, bus.medir, bus.transmitir,
            bus.sel_char, bus.avanca_posicao, bus.pronto, bus.erro_medida}, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("post_reset_prepara", {bus.db_estado, bus.zera}, {4'h1, 1'b1});
        step();
        serve_frame(-1, 0);

`ifdef SONAR_UC_WATCHDOG_EN
        reset_dut();
        bus.ligar = 1'b1;
        step();
        step();
        step();
        chk("wd_aguarda", {28'd0, bus.db_estado}, 32'h3);
        n = 0;
        repeat (49) begin
            step();
            if (bus.db_estado == 4'h3 && !bus.erro_medida) n++;
        end
        chk("wd_wait", n, 49);
        step();
        chk("wd_erro", {bus.db_estado, bus.erro_medida}, {4'hF, 1'b1});
        step();
        chk("wd_espera", {bus.db_estado, bus.erro_medida}, {4'h7, 1'b1});
        repeat (19) step();
        step();
        chk("wd_move", {bus.db_estado, bus.avanca_posicao, bus.pronto, bus.erro_medida},
            {4'h8, 1'b1, 1'b1, 1'b1});
        step();
        chk("wd_sticky", {bus.db_estado, bus.medir, bus.erro_medida}, {4'h2, 1'b1, 1'b1});
        step();
        repeat (50) step();
        step();
        bus.ligar = 1'b0;
        repeat (20) step();
        step();
        chk("wd_inicial", {bus.db_estado, bus.erro_medida}, {4'h0, 1'b1});
        bus.ligar = 1'b1;
        step();
        chk("wd_clear", {bus.db_estado, bus.zera, bus.erro_medida}, {4'h1, 1'b1, 1'b0});
        step();
        step();
        repeat (49) step();
        bus.fim_medicao = 1'b1;
        step();
        bus.fim_medicao = 1'b0;
        chk("wd_tie", {bus.db_estado, bus.transmitir, bus.erro_medida}, {4'h4, 1'b1, 1'b0});
`else
        reset_dut();
        bus.ligar = 1'b1;
        step();
        step();
        step();
        n = 0;
        repeat (60) begin
            step();
            if (bus.db_estado == 4'h3 && !bus.erro_medida) n++;
        end
        chk("no_watchdog", n, 60);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
